// File: rtl/wb_timer16_pkg.sv
// Shared register map and bit positions for the 16-bit WISHBONE timer.
package wb_timer16_pkg;

  localparam logic [2:0] TMR_CNT_L = 3'd0;
  localparam logic [2:0] TMR_CNT_H = 3'd1;
  localparam logic [2:0] TMR_CMP_L = 3'd2;
  localparam logic [2:0] TMR_CMP_H = 3'd3;
  localparam logic [2:0] TMR_CTRL  = 3'd4;
  localparam logic [2:0] TMR_STAT  = 3'd5;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_CTC    = 1;
  localparam int unsigned CTRL_PS_LSB = 2;
  localparam int unsigned CTRL_PS_MSB = 4;
  localparam int unsigned CTRL_IE     = 7;

  localparam int unsigned STAT_CMPF = 0;
  localparam int unsigned STAT_OVF  = 1;

  typedef struct packed {
    logic       ie;
    logic [2:0] ps;
    logic       ctc;
    logic       en;
  } ctrl_t;

  function automatic logic [7:0] ctrl_byte(ctrl_t c);
    logic [7:0] b;
    b = '0;
    b[CTRL_EN]                  = c.en;
    b[CTRL_CTC]                 = c.ctc;
    b[CTRL_PS_MSB:CTRL_PS_LSB]  = c.ps;
    b[CTRL_IE]                  = c.ie;
    return b;
  endfunction

endpackage

// File: rtl/wb_timer16_if.sv
// 8-bit WISHBONE I/O bus between the CPU bridge (master) and a peripheral (slave).
interface wb_timer16_if;
  logic [7:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic [7:0] wb_dat_o;
  logic       wb_stb_i;
  logic       wb_we_i;
  logic       wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_stb_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_stb_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_slave_if.sv
// Generic WISHBONE slave front end: 8-byte window decode, single-cycle ack pulse,
// registered read data. Access strobes are valid in the cycle before ack rises.
module wb_slave_if #(
  parameter logic [7:0] BASE_ADR = 8'h00
) (
  input  logic       clk_i,
  input  logic       rst_i,
  wb_timer16_if.slave wb,
  input  logic [7:0] rdata_i,
  output logic       wr_o,
  output logic       rd_o,
  output logic [2:0] offset_o,
  output logic [7:0] wdata_o
);

  logic       ack_q;
  logic [7:0] dat_q;
  logic       sel;

  // Masking with ack_q forces a held strobe to re-ack only every other cycle.
  assign sel      = wb.wb_stb_i & (wb.wb_adr_i[7:3] == BASE_ADR[7:3]) & ~ack_q;
  assign wr_o     = sel & wb.wb_we_i;
  assign rd_o     = sel & ~wb.wb_we_i;
  assign offset_o = wb.wb_adr_i[2:0];
  assign wdata_o  = wb.wb_dat_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= sel;
      dat_q <= rd_o ? rdata_i : '0;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

endmodule

// File: rtl/wb_timer16.sv
// 16-bit prescaled timer/counter with compare, clear-on-compare and overflow
// flags, behind an 8-bit WISHBONE register window.
module wb_timer16
  import wb_timer16_pkg::*;
#(
  parameter logic [7:0]  BASE_ADR = 8'h00,
  parameter int unsigned PRE_W    = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_timer16_if.slave wb,
  output logic        irq_o,
  input  logic        irq_ack_i,
  output logic        cmp_o
);

  logic       wr, rd;
  logic [2:0] offset;
  logic [7:0] wdata, rdata;

  wb_slave_if #(
    .BASE_ADR(BASE_ADR)
  ) u_slave (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wb      (wb),
    .rdata_i (rdata),
    .wr_o    (wr),
    .rd_o    (rd),
    .offset_o(offset),
    .wdata_o (wdata)
  );

  logic [15:0]      cnt_q, cnt_d, cmp_q, cmp_d;
  logic [7:0]       temp_q, temp_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             cmpf_q, cmpf_d, ovf_q, ovf_d;
  logic [PRE_W-1:0] pre_q, pre_d, pre_mask;
  logic             irq_q, cmp_pulse_q;
  logic             tick, set_cmpf, set_ovf;

  // Mask bits only exist up to PRE_W, so a PS beyond the prescaler width saturates.
  always_comb begin
    pre_mask = '0;
    for (int unsigned i = 0; i < PRE_W; i++) begin
      pre_mask[i] = (i < 32'(ctrl_q.ps));
    end
  end

  assign tick  = ctrl_q.en & ((pre_q & pre_mask) == pre_mask);
  assign pre_d = ctrl_q.en ? pre_q + 1'b1 : '0;

  always_comb begin
    cnt_d    = cnt_q;
    set_cmpf = 1'b0;
    set_ovf  = 1'b0;
    // A CNT_L write swallows any tick in the same cycle.
    if (wr && offset == TMR_CNT_L) begin
      cnt_d = {temp_q, wdata};
    end else if (tick) begin
      if (cnt_q == cmp_q) begin
        set_cmpf = 1'b1;
        set_ovf  = ctrl_q.ctc & (cnt_q == 16'hFFFF);
        cnt_d    = ctrl_q.ctc ? '0 : cnt_q + 16'd1;
      end else if (cnt_q == 16'hFFFF) begin
        set_ovf = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    cmp_d  = cmp_q;
    temp_d = temp_q;
    ctrl_d = ctrl_q;
    if (rd && offset == TMR_CNT_L) temp_d = cnt_q[15:8];
    if (wr) begin
      case (offset)
        TMR_CNT_H, TMR_CMP_H: temp_d = wdata;
        TMR_CMP_L:            cmp_d  = {temp_q, wdata};
        TMR_CTRL: begin
          ctrl_d.en  = wdata[CTRL_EN];
          ctrl_d.ctc = wdata[CTRL_CTC];
          ctrl_d.ps  = wdata[CTRL_PS_MSB:CTRL_PS_LSB];
          ctrl_d.ie  = wdata[CTRL_IE];
        end
        default: ;
      endcase
    end
  end

  // Clears first, then sets, so a flag raised this cycle always survives.
  always_comb begin
    cmpf_d = cmpf_q;
    ovf_d  = ovf_q;
    if (wr && offset == TMR_STAT) begin
      if (wdata[STAT_CMPF]) cmpf_d = 1'b0;
      if (wdata[STAT_OVF])  ovf_d  = 1'b0;
    end
    if (irq_ack_i) begin
      if (cmpf_q) cmpf_d = 1'b0;
      else        ovf_d  = 1'b0;
    end
    if (set_cmpf) cmpf_d = 1'b1;
    if (set_ovf)  ovf_d  = 1'b1;
  end

  always_comb begin
    rdata = '0;
    case (offset)
      TMR_CNT_L: rdata = cnt_q[7:0];
      TMR_CNT_H: rdata = temp_q;
      TMR_CMP_L: rdata = cmp_q[7:0];
      TMR_CMP_H: rdata = cmp_q[15:8];
      TMR_CTRL:  rdata = ctrl_byte(ctrl_q);
      TMR_STAT: begin
        rdata[STAT_CMPF] = cmpf_q;
        rdata[STAT_OVF]  = ovf_q;
      end
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q       <= '0;
      cmp_q       <= '0;
      temp_q      <= '0;
      ctrl_q      <= '0;
      cmpf_q      <= 1'b0;
      ovf_q       <= 1'b0;
      pre_q       <= '0;
      irq_q       <= 1'b0;
      cmp_pulse_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cmp_q       <= cmp_d;
      temp_q      <= temp_d;
      ctrl_q      <= ctrl_d;
      cmpf_q      <= cmpf_d;
      ovf_q       <= ovf_d;
      pre_q       <= pre_d;
      irq_q       <= ctrl_q.ie & (cmpf_q | ovf_q);
      cmp_pulse_q <= set_cmpf;
    end
  end

  assign irq_o = irq_q;
  assign cmp_o = cmp_pulse_q;

endmodule

// File: tb/tb_wb_timer16.sv
// Self-checking bench for wb_timer16: directed scenarios plus randomized bus traffic,
// compared cycle by cycle against an arithmetic model of the timer.
module tb_wb_timer16;
  import wb_timer16_pkg::*;

  localparam logic [7:0] Base = 8'h40;

  logic clk_i     = 1'b0;
  logic rst_i     = 1'b0;
  logic irq_ack_i = 1'b0;
  logic irq_o, cmp_o;

  wb_timer16_if wb_bus ();

  wb_timer16 #(
    .BASE_ADR(Base),
    .PRE_W   (7)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wb       (wb_bus),
    .irq_o    (irq_o),
    .irq_ack_i(irq_ack_i),
    .cmp_o    (cmp_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state
  int unsigned m_cnt, m_cmp, m_temp, m_pre, m_ps, m_dat;
  bit          m_en, m_ctc, m_ie, m_cmpf, m_ovf, m_ack, m_irq, m_cmpo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_cmp = 0; m_temp = 0; m_pre = 0; m_ps = 0; m_dat = 0;
    m_en = 0; m_ctc = 0; m_ie = 0; m_cmpf = 0; m_ovf = 0; m_ack = 0; m_irq = 0; m_cmpo = 0;
  endtask

  // One clock: predict from current inputs, advance, then compare all outputs.
  task automatic step();
    int unsigned off, d, div, n_cnt, n_cmp, n_temp, n_dat, n_pre;
    bit sel, wr, rd, tick, set_c, set_o, n_cmpf, n_ovf, n_en, n_ctc, n_ie;
    int unsigned n_ps;
    sel  = wb_bus.wb_stb_i && ((wb_bus.wb_adr_i >> 3) == (Base >> 3)) && !m_ack;
    off  = int'(wb_bus.wb_adr_i) % 8;
    d    = int'(wb_bus.wb_dat_i);
    wr   = sel && wb_bus.wb_we_i;
    rd   = sel && !wb_bus.wb_we_i;
    div  = 1 << ((m_ps > 7) ? 7 : m_ps);
    tick = m_en && ((m_pre % div) == div - 1);

    n_dat = 0;
    if (rd) begin
      case (off)
        0: n_dat = m_cnt % 256;
        1: n_dat = m_temp;
        2: n_dat = m_cmp % 256;
        3: n_dat = m_cmp / 256;
        4: n_dat = m_ie * 128 + m_ps * 4 + m_ctc * 2 + m_en;
        5: n_dat = m_ovf * 2 + m_cmpf;
        default: n_dat = 0;
      endcase
    end

    n_temp = m_temp;
    if (rd && off == 0) n_temp = m_cnt / 256;
    if (wr && (off == 1 || off == 3)) n_temp = d;
    n_cmp = m_cmp;
    if (wr && off == 2) n_cmp = m_temp * 256 + d;
    n_en = m_en; n_ctc = m_ctc; n_ps = m_ps; n_ie = m_ie;
    if (wr && off == 4) begin
      n_en = d[0]; n_ctc = d[1]; n_ps = (d >> 2) % 8; n_ie = d[7];
    end

    n_cnt = m_cnt; set_c = 0; set_o = 0;
    if (wr && off == 0) n_cnt = m_temp * 256 + d;
    else if (tick) begin
      if (m_cnt == m_cmp) begin
        set_c = 1;
        if (m_ctc) begin
          n_cnt = 0;
          set_o = (m_cnt == 65535);
        end else n_cnt = (m_cnt + 1) % 65536;
      end else if (m_cnt == 65535) begin
        n_cnt = 0; set_o = 1;
      end else n_cnt = m_cnt + 1;
    end

    n_cmpf = m_cmpf; n_ovf = m_ovf;
    if (wr && off == 5) begin
      if (d % 2 == 1) n_cmpf = 0;
      if ((d / 2) % 2 == 1) n_ovf = 0;
    end
    if (irq_ack_i) begin
      if (m_cmpf) n_cmpf = 0;
      else n_ovf = 0;
    end
    if (set_c) n_cmpf = 1;
    if (set_o) n_ovf = 1;
    n_pre = m_en ? (m_pre + 1) % 128 : 0;

    @(posedge clk_i);
    m_irq = m_ie && (m_cmpf || m_ovf);
    m_cmpo = set_c; m_ack = sel; m_dat = n_dat;
    m_cnt = n_cnt; m_cmp = n_cmp; m_temp = n_temp; m_pre = n_pre;
    m_en = n_en; m_ctc = n_ctc; m_ps = n_ps; m_ie = n_ie; m_cmpf = n_cmpf; m_ovf = n_ovf;
    #1;
    check("ack", wb_bus.wb_ack_o, m_ack);
    check("dat", wb_bus.wb_dat_o, m_dat);
    check("irq", irq_o, m_irq);
    check("cmp_o", cmp_o, m_cmpo);
  endtask

  task automatic bus_xfer(input logic [2:0] off, input bit w, input logic [7:0] d,
                          output logic [7:0] r);
    int n = 0;
    wb_bus.wb_adr_i = {Base[7:3], off};
    wb_bus.wb_we_i  = w;
    wb_bus.wb_dat_i = d;
    wb_bus.wb_stb_i = 1'b1;
    do begin
      step();
      n++;
    end while (wb_bus.wb_ack_o !== 1'b1 && n < 6);
    check("ack_latency", n, 1);
    r = wb_bus.wb_dat_o;
    wb_bus.wb_stb_i = 1'b0;
    wb_bus.wb_we_i  = 1'b0;
    step();
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    logic [7:0] r;
    bus_xfer(off, 1'b1, d, r);
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] r);
    bus_xfer(off, 1'b0, 8'h00, r);
  endtask

  task automatic nomatch(input int cycles);
    wb_bus.wb_adr_i = Base + 8'd8;
    wb_bus.wb_we_i  = 1'b0;
    wb_bus.wb_stb_i = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      step();
      check("nomatch_ack", wb_bus.wb_ack_o, 1'b0);
      check("nomatch_dat", wb_bus.wb_dat_o, 8'h00);
    end
    wb_bus.wb_stb_i = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] r;
    int n;
    wb_bus.wb_adr_i = '0; wb_bus.wb_dat_i = '0; wb_bus.wb_stb_i = 1'b0; wb_bus.wb_we_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack", wb_bus.wb_ack_o, 1'b0);
    check("rst_irq", irq_o, 1'b0);
    check("rst_cmp_o", cmp_o, 1'b0);
    @(negedge clk_i) rst_i = 1'b1;

    // Every register reads zero after reset
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), r);
      check("reset_read", r, 8'h00);
    end

    // Shared TEMP byte, then atomic 16-bit read while counting
    wr(TMR_CNT_H, 8'h12);
    wr(TMR_CNT_L, 8'h34);
    rd(TMR_CNT_L, r); check("cnt_l_rd", r, 8'h34);
    rd(TMR_CNT_H, r); check("cnt_h_rd", r, 8'h12);
    wr(TMR_CNT_H, 8'h12);
    wr(TMR_CNT_L, 8'hFE);
    wr(TMR_CTRL, 8'h01);
    rd(TMR_CNT_L, r); check("atomic_lo", r, 8'hFF);
    rd(TMR_CNT_H, r); check("atomic_hi", r, 8'h12);
    wr(TMR_CTRL, 8'h00);

    // Clear-on-compare at 5 with interrupt
    wr(TMR_CMP_H, 8'h00);
    wr(TMR_CMP_L, 8'h05);
    wr(TMR_CNT_H, 8'h00);
    wr(TMR_CNT_L, 8'h00);
    wr(TMR_CTRL, 8'h83);
    n = 0;
    while (cmp_o !== 1'b1 && n < 40) begin step(); n++; end
    check("cmp_pulse_seen", cmp_o, 1'b1);
    check("irq_lags_cmpf", irq_o, 1'b0);
    step();
    check("irq_after_cmpf", irq_o, 1'b1);
    n = 1;
    while (cmp_o !== 1'b1 && n < 40) begin step(); n++; end
    check("ctc_period", n, 6);
    wr(TMR_CTRL, 8'h80);
    check("irq_held", irq_o, 1'b1);
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    step();
    check("irq_cleared", irq_o, 1'b0);

    // Overflow with PS=3: OVF lands on the 16th clock after enable
    wr(TMR_CTRL, 8'h00);
    wr(TMR_STAT, 8'h03);
    wr(TMR_CNT_H, 8'hFF);
    wr(TMR_CNT_L, 8'hFE);
    wr(TMR_CTRL, 8'h0D);
    repeat (14) step();
    rd(TMR_STAT, r); check("ovf_not_yet", r & 8'h02, 8'h00);
    rd(TMR_STAT, r); check("ovf_set", r & 8'h02, 8'h02);
    check("irq_masked", irq_o, 1'b0);
    wr(TMR_STAT, 8'h02);
    rd(TMR_STAT, r); check("ovf_cleared", r & 8'h02, 8'h00);

    // CNT_L write beats a tick in the same cycle
    wr(TMR_CTRL, 8'h00);
    wr(TMR_CMP_H, 8'h80);
    wr(TMR_CMP_L, 8'h00);
    wr(TMR_CNT_H, 8'h00);
    wr(TMR_CTRL, 8'h01);
    wr(TMR_CNT_L, 8'h00);
    rd(TMR_CNT_L, r); check("cnt_write_wins", r, 8'h01);

    // Compare set beats a simultaneous STAT clear
    wr(TMR_CTRL, 8'h00);
    wr(TMR_CMP_H, 8'h00);
    wr(TMR_CMP_L, 8'h01);
    wr(TMR_STAT, 8'h03);
    wr(TMR_CNT_H, 8'h00);
    wr(TMR_CTRL, 8'h01);
    wr(TMR_CNT_L, 8'h00);
    wr(TMR_STAT, 8'h01);
    rd(TMR_STAT, r); check("cmpf_set_wins", r & 8'h01, 8'h01);
    wr(TMR_CTRL, 8'h00);

    // Unmatched window, then reset in the middle of a matched access
    nomatch(10);
    wr(TMR_CTRL, 8'h83);
    wr(TMR_CMP_L, 8'h07);
    wb_bus.wb_adr_i = {Base[7:3], TMR_CTRL};
    wb_bus.wb_stb_i = 1'b1;
    step();
    check("ack_before_rst", wb_bus.wb_ack_o, 1'b1);
    rst_i = 1'b0;
    #1;
    check("ack_dropped_by_rst", wb_bus.wb_ack_o, 1'b0);
    check("dat_cleared_by_rst", wb_bus.wb_dat_o, 8'h00);
    model_reset();
    wb_bus.wb_stb_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), r);
      check("post_rst_read", r, 8'h00);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      int unsigned k;
      logic [2:0] off;
      logic [7:0] d;
      bit w;
      k = $urandom_range(0, 2);
      for (int j = 0; j < int'(k); j++) begin
        irq_ack_i = ($urandom_range(0, 3) == 0);
        step();
        irq_ack_i = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) begin
        nomatch(2);
      end else begin
        off = 3'($urandom_range(0, 7));
        w   = 1'($urandom_range(0, 1));
        d   = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
        if (off == TMR_CTRL) d[4:2] = 3'($urandom_range(0, 2));
        bus_xfer(off, w, d, r);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_timer16.md
Name: wb_timer16

Overview:
- WISHBONE slave 16-bit timer/counter. It is the responder end of the CPU's 8-bit WISHBONE I/O bridge.
- Its interrupt request drives the CPU's external device interrupt 2 (16-bit timer line); the CPU's acknowledge for that line clears the request.
- Provides a prescaled up-counter, a compare register, clear-on-compare mode, and compare/overflow flags.

Parameters:
- BASE_ADR, 8'h00, base of the 8-byte register window; decode is wb_adr_i[7:3]==BASE_ADR[7:3].
- PRE_W, 7, prescaler counter width; the maximum divide is 2^PRE_W.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, asynchronous, active-low.
- wb_adr_i  in  8  I/O address from the bridge.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data, valid only while wb_ack_o=1.
- wb_stb_i  in  1  strobe; held by the bridge until ack.
- wb_we_i  in  1  1=write, 0=read.
- wb_ack_o  out  1  acknowledge, one-cycle pulse.
- irq_o  out  1  interrupt request to the CPU.
- irq_ack_i  in  1  CPU interrupt acknowledge, one-cycle pulse.
- cmp_o  out  1  one-cycle pulse on each compare match.

Behaviour:
- Reset (rst_i=0, async): all registers 0; wb_ack_o=0, wb_dat_o=0, irq_o=0, cmp_o=0. The timer is disabled after reset.
- Handshake:
  - sel = wb_stb_i & address match & !wb_ack_o.
  - wb_ack_o is registered: it goes 1 the cycle after sel and 0 the following cycle, so ack is always a single-cycle pulse.
  - A held strobe re-acks every 2 cycles.
  - An unmatched address never acks; wb_dat_o stays 0.
- Access timing: register writes and read side effects happen on the clock edge where wb_ack_o goes 1. wb_dat_o is registered and valid in the same cycle as ack, 0 otherwise.
- Register map (offset = wb_adr_i[2:0]):
  - 0 CNT_L: read returns cnt[7:0] and latches cnt[15:8] into TEMP. Write commits cnt={TEMP,data}.
  - 1 CNT_H: read returns TEMP. Write sets TEMP=data.
  - 2 CMP_L: read returns cmp[7:0]. Write commits cmp={TEMP,data}.
  - 3 CMP_H: read returns cmp[15:8]. Write sets TEMP=data.
  - 4 CTRL: bit0 EN, bit1 CTC (clear on compare), bits4:2 PS, bit7 IE. Bits 6:5 read 0.
  - 5 STAT: bit0 CMPF, bit1 OVF. Writing 1 to a bit clears that flag.
  - 6, 7: read 0, writes ignored.
  - TEMP is a single shared byte.
- Prescaler:
  - pre counts every clock while EN=1 and is held at 0 while EN=0.
  - tick = EN & (pre[PS-1:0] == all ones); the divide is 2^PS, and PS=0 gives a tick every clock.
  - The PS field is clamped to PRE_W.
- On tick:
  - If cnt==cmp: set CMPF and pulse cmp_o. cnt becomes 0 if CTC=1, otherwise cnt+1.
  - Else if cnt==16'hFFFF: cnt wraps to 0 and OVF is set.
  - Else cnt+1.
  - With CTC=1 and cmp=16'hFFFF, the count wraps to 0 and sets both CMPF and OVF.
- Collisions:
  - A CNT_L write on a tick cycle wins; the increment is lost and no compare/overflow is evaluated for that tick.
  - Flag set (tick) beats flag clear (STAT write or irq_ack_i) in the same cycle.
- Interrupt:
  - irq_o = IE & (CMPF | OVF), registered.
  - irq_ack_i clears CMPF if it is set, otherwise OVF (compare has priority).
  - While IE=0, the flags still update.
- Reset mid-transaction: ack is dropped immediately. The bridge re-issues the access after reset, no partial write is retained, and TEMP is cleared.

Decomposition:
- Shared avr package constants: register offsets TMR_CNT_L..TMR_STAT, CTRL bit positions, flag bit positions.
- One sub-module: wb_slave_if, which does address decode, ack pulse generation, and read-data register. It is reusable by future WISHBONE slaves.
- The timer core stays in wb_timer16.

Test Plan:
- Reset, then read all 8 offsets → each ack arrives 1 cycle after stb, data 0x00, irq_o=0.
- Write CNT_H=0x12, CNT_L=0x34, then read CNT_L then CNT_H with EN=0 → 0x34, 0x12. Atomic check: with PS=0, EN=1, cnt at 0x12FF, read CNT_L=0xFF, then CNT_H returns 0x12, not 0x13.
- cmp=0x0005, CTRL=0x83 (EN, CTC, IE, PS=0) → counter sequence 0..5,0,…; cmp_o pulses at cnt=5; irq_o=1 one cycle after CMPF sets; irq_ack_i clears CMPF and irq_o drops.
- CTRL=0x0D (EN, PS=3), cnt=0xFFFE → tick every 8 clocks; OVF set after the 16th clock; writing STAT=0x02 clears it.
- Tick coincides with a CNT_L write of 0x00 (TEMP=0x00) → cnt=0x0000, no increment; STAT write on the same cycle as compare set → CMPF remains 1.
- Access to BASE_ADR+8 (no match) with stb held 10 cycles → no ack, wb_dat_o=0; assert rst_i=0 during a matched stb → ack=0 immediately and all registers 0.
